// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle IF/ID/EXE/MEM/WB main controller for the MIPS-subset core
// Optional build macro ILLEGAL_TRAP_EN: unsupported instructions halt in TRAP instead of running as NOP.
module mc_ctrl_fsm #(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IRWr,
    output logic       PCWr,
    output logic [1:0] PCSrc,
    output logic       RegWr,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrc,
    output logic [2:0] ALUOp,
    output logic       ExtOp,
    output logic       MemRd,
    output logic       MemWr,
    output logic       instr_done,
    output logic       trap,
    output logic [2:0] state
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EXE  = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_TRAP = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_LUI  = 3'd4;

    logic [2:0] state_q, state_d;

    logic is_rtype, is_alu_r, is_jr, is_j, is_jal, is_beq;
    logic is_ori, is_lui, is_lw, is_sw, is_legal;
    logic req_done;
    logic [2:0] r_aluop;

    logic       c_mem_req, c_irwr, c_pcwr, c_regwr, c_alusrc, c_extop, c_memrd, c_memwr;
    logic [1:0] c_pcsrc, c_regdst, c_memtoreg;
    logic [2:0] c_aluop;
    logic       c_trap;

    always_comb begin
        is_rtype = (op == OP_RTYPE);
        is_alu_r = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_SLT));
        is_jr    = is_rtype && (funct == FN_JR);
        is_j     = (op == OP_J);
        is_jal   = (op == OP_JAL);
        is_beq   = (op == OP_BEQ);
        is_ori   = (op == OP_ORI);
        is_lui   = (op == OP_LUI);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_legal = is_alu_r || is_jr || is_j || is_jal || is_beq || is_ori || is_lui || is_lw || is_sw;
        if (funct == FN_SUBU) begin
            r_aluop = ALU_SUB;
        end else if (funct == FN_SLT) begin
            r_aluop = ALU_SLT;
        end else begin
            r_aluop = ALU_ADD;
        end
    end

    // With a single-cycle memory every request completes in the cycle it is issued.
    assign req_done = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    always_comb begin
        state_d    = state_q;
        c_mem_req  = 1'b0;
        c_irwr     = 1'b0;
        c_pcwr     = 1'b0;
        c_pcsrc    = 2'd0;
        c_regwr    = 1'b0;
        c_regdst   = 2'd0;
        c_memtoreg = 2'd0;
        c_alusrc   = 1'b0;
        c_aluop    = ALU_ADD;
        c_extop    = 1'b0;
        c_memrd    = 1'b0;
        c_memwr    = 1'b0;
        case (state_q)
            S_IF: begin
                c_mem_req = 1'b1;
                if (req_done) begin
                    c_irwr  = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (is_j) begin
                    c_pcwr  = 1'b1;
                    c_pcsrc = 2'd3;
                    state_d = S_IF;
                end else if (is_jr) begin
                    c_pcwr  = 1'b1;
                    c_pcsrc = 2'd2;
                    state_d = S_IF;
                end else if (is_jal) begin
                    state_d = S_WB;
                end else if (is_legal) begin
                    state_d = S_EXE;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    c_pcwr  = 1'b1;
                    state_d = S_IF;
`endif
                end
            end
            S_EXE: begin
                state_d = (is_lw || is_sw) ? S_MEM : S_WB;
                if (is_rtype) begin
                    c_aluop = r_aluop;
                end else if (is_ori) begin
                    c_alusrc = 1'b1;
                    c_aluop  = ALU_OR;
                end else if (is_lui) begin
                    c_alusrc = 1'b1;
                    c_aluop  = ALU_LUI;
                end else if (is_lw || is_sw) begin
                    c_alusrc = 1'b1;
                    c_extop  = 1'b1;
                end else if (is_beq) begin
                    // Branch resolves here: PC takes the target or PC+4 and the instruction retires.
                    c_aluop = ALU_SUB;
                    c_pcwr  = 1'b1;
                    c_pcsrc = Zero ? 2'd1 : 2'd0;
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                c_mem_req = 1'b1;
                c_memrd   = is_lw;
                c_memwr   = is_sw;
                if (req_done) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        c_pcwr  = 1'b1;
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                c_regwr = 1'b1;
                c_pcwr  = 1'b1;
                state_d = S_IF;
                if (is_jal) begin
                    c_pcsrc    = 2'd3;
                    c_regdst   = 2'd2;
                    c_memtoreg = 2'd2;
                end else if (is_rtype) begin
                    c_regdst = 2'd1;
                end else if (is_lw) begin
                    c_memtoreg = 2'd1;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign c_trap = (state_q == S_TRAP);
`else
    assign c_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset forces every control low immediately, even though state already reads IF.
    assign mem_req    = reset & c_mem_req;
    assign IRWr       = reset & c_irwr;
    assign PCWr       = reset & c_pcwr;
    assign instr_done = reset & c_pcwr;
    assign PCSrc      = reset ? c_pcsrc : 2'd0;
    assign RegWr      = reset & c_regwr;
    assign RegDst     = reset ? c_regdst : 2'd0;
    assign MemtoReg   = reset ? c_memtoreg : 2'd0;
    assign ALUSrc     = reset & c_alusrc;
    assign ALUOp      = reset ? c_aluop : 3'd0;
    assign ExtOp      = reset & c_extop;
    assign MemRd      = reset & c_memrd;
    assign MemWr      = reset & c_memwr;
    assign trap       = reset & c_trap;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - randomized scoreboard bench for mc_ctrl_fsm
// Optional build macro ILLEGAL_TRAP_EN selects the trap expectations.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, IRWr, PCWr, RegWr, ALUSrc, ExtOp, MemRd, MemWr, instr_done, trap;
    logic [1:0] PCSrc, RegDst, MemtoReg;
    logic [2:0] ALUOp, state;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_HANDSHAKE(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc), .RegWr(RegWr),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ExtOp(ExtOp),
        .MemRd(MemRd), .MemWr(MemWr), .instr_done(instr_done), .trap(trap), .state(state)
    );

    localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_ORI = 4, K_LUI = 5;
    localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10, K_ILL = 11;

    typedef struct {
        int cycles;
        int pcsrc;
        int regwr;
        int regdst;
        int memtoreg;
        int aluop;
        int alusrc;
        int extop;
        int nrd;
        int nwr;
        int nreq;
        int nirwr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: what one instruction should look like from retirement to retirement.
    function automatic exp_t model(input int kind, input bit z, input int wi, input int wm);
        exp_t e;
        e = '{cycles: 0, pcsrc: 0, regwr: 0, regdst: 0, memtoreg: 0, aluop: 0,
              alusrc: 0, extop: 0, nrd: 0, nwr: 0, nreq: wi + 1, nirwr: 1};
        case (kind)
            K_ADDU: begin e.cycles = 4; e.regwr = 1; e.regdst = 1; end
            K_SUBU: begin e.cycles = 4; e.regwr = 1; e.regdst = 1; e.aluop = 1; end
            K_SLT:  begin e.cycles = 4; e.regwr = 1; e.regdst = 1; e.aluop = 3; end
            K_JR:   begin e.cycles = 2; e.pcsrc = 2; end
            K_ORI:  begin e.cycles = 4; e.regwr = 1; e.aluop = 2; e.alusrc = 1; end
            K_LUI:  begin e.cycles = 4; e.regwr = 1; e.aluop = 4; e.alusrc = 1; end
            K_LW:   begin
                e.cycles = 5 + wm; e.regwr = 1; e.memtoreg = 1; e.alusrc = 1; e.extop = 1;
                e.nrd = wm + 1; e.nreq = e.nreq + wm + 1;
            end
            K_SW:   begin
                e.cycles = 4 + wm; e.alusrc = 1; e.extop = 1;
                e.nwr = wm + 1; e.nreq = e.nreq + wm + 1;
            end
            K_BEQ:  begin e.cycles = 3; e.aluop = 1; e.pcsrc = z ? 1 : 0; end
            K_J:    begin e.cycles = 2; e.pcsrc = 3; end
            K_JAL:  begin e.cycles = 3; e.pcsrc = 3; e.regwr = 1; e.regdst = 2; e.memtoreg = 2; end
            default: begin e.cycles = 2; end
        endcase
        e.cycles = e.cycles + wi;
        return e;
    endfunction

    task automatic encode(input int kind, output logic [5:0] o, output logic [5:0] f);
        o = 6'h00;
        f = 6'($urandom_range(0, 63));
        case (kind)
            K_ADDU: f = 6'h21;
            K_SUBU: f = 6'h23;
            K_SLT:  f = 6'h2A;
            K_JR:   f = 6'h08;
            K_ORI:  o = 6'h0D;
            K_LUI:  o = 6'h0F;
            K_LW:   o = 6'h23;
            K_SW:   o = 6'h2B;
            K_BEQ:  o = 6'h04;
            K_J:    o = 6'h02;
            K_JAL:  o = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 1) o = 6'h3F;
                else f = 6'h20;
            end
        endcase
    endtask

    int   cyc = 0, a_rd = 0, a_wr = 0, a_req = 0, a_irwr = 0;
    int   a_regwr = 0, a_regdst = 0, a_m2r = 0, a_aluop = 0, a_alusrc = 0, a_extop = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            cyc++;
            if (MemRd) a_rd++;
            if (MemWr) a_wr++;
            if (mem_req) a_req++;
            if (IRWr) a_irwr++;
            if (state == 3'd2) begin
                a_aluop = int'(ALUOp); a_alusrc = int'(ALUSrc); a_extop = int'(ExtOp);
            end
            if (RegWr) begin
                a_regwr = 1; a_regdst = int'(RegDst); a_m2r = int'(MemtoReg);
            end
            check("instr_done_eq_pcwr", int'(instr_done), int'(PCWr));
            if (PCWr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cycles", cyc, e.cycles);
                    check("pcsrc", int'(PCSrc), e.pcsrc);
                    check("regwr", a_regwr, e.regwr);
                    check("regdst", a_regdst, e.regdst);
                    check("memtoreg", a_m2r, e.memtoreg);
                    check("aluop", a_aluop, e.aluop);
                    check("alusrc", a_alusrc, e.alusrc);
                    check("extop", a_extop, e.extop);
                    check("memrd_cycles", a_rd, e.nrd);
                    check("memwr_cycles", a_wr, e.nwr);
                    check("mem_req_cycles", a_req, e.nreq);
                    check("irwr_count", a_irwr, e.nirwr);
                end
                cyc = 0; a_rd = 0; a_wr = 0; a_req = 0; a_irwr = 0;
                a_regwr = 0; a_regdst = 0; a_m2r = 0; a_aluop = 0; a_alusrc = 0; a_extop = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   kind, wi, wm, mem_start;
        bit   z;
        exp_t e;
        logic [5:0] o, f;

        reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_mem_req", int'(mem_req), 0);
        check("rst_pcwr", int'(PCWr), 0);
        check("rst_irwr", int'(IRWr), 0);
        check("rst_trap", int'(trap), 0);
        tick();
        reset = 1'b1;
        mon_en = 1;

        for (int n = 0; n < 200; n++) begin
`ifdef ILLEGAL_TRAP_EN
            kind = $urandom_range(0, 10);
`else
            kind = $urandom_range(0, 11);
`endif
            z  = 1'($urandom_range(0, 1));
            wi = $urandom_range(0, 2);
            wm = $urandom_range(0, 2);
            encode(kind, o, f);
            op = o; funct = f; Zero = z;
            e = model(kind, z, wi, wm);
            exp_q.push_back(e);
            mem_start = wi + 3;
            for (int c = 0; c < e.cycles; c++) begin
                if (c < wi) mem_ready = 1'b0;
                else if (c == wi) mem_ready = 1'b1;
                else if ((kind == K_LW || kind == K_SW) && c >= mem_start && c < mem_start + wm)
                    mem_ready = 1'b0;
                else if ((kind == K_LW || kind == K_SW) && c == mem_start + wm)
                    mem_ready = 1'b1;
                else mem_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        mon_en = 0;

        op = 6'h23; funct = 6'h00; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check("lw_mem_state", int'(state), 3);
        check("lw_mem_memrd", int'(MemRd), 1);
        reset = 1'b0;
        #1;
        check("midrst_state", int'(state), 0);
        check("midrst_memrd", int'(MemRd), 0);
        check("midrst_mem_req", int'(mem_req), 0);
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("release_state", int'(state), 0);
        check("release_mem_req", int'(mem_req), 1);
        check("release_irwr", int'(IRWr), 1);

        op = 6'h3F;
        tick();
        #1;
        check("ill_id_state", int'(state), 1);
`ifdef ILLEGAL_TRAP_EN
        check("ill_id_pcwr", int'(PCWr), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("trap_state", int'(state), 5);
            check("trap_flag", int'(trap), 1);
            check("trap_pcwr", int'(PCWr), 0);
            check("trap_mem_req", int'(mem_req), 0);
        end
`else
        check("nop_pcwr", int'(PCWr), 1);
        check("nop_pcsrc", int'(PCSrc), 0);
        check("nop_trap", int'(trap), 0);
        tick();
        #1;
        check("nop_next_state", int'(state), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
